grid_word_deframer: RTL and testbench
=====================================

Name: grid_word_deframer

Overview:
- Receive-side counterpart of the grid top's byte-folded output path.
- Accepts an 8-bit byte stream, locates frames (sync, 4 payload bytes LSB-first, checksum), and rebuilds 32-bit grid words.
- Queues good words in a small FIFO with a valid/ready output handshake.
- Also presents the 8-bit fold of each delivered word, so a bench can cross-check it against the grid's uo_out fold.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- FIFO_DEPTH, 4, word FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  reset; synchronous, active-high (1 = reset, despite the codebase name).
- byte_in  input  8  stream byte; sampled only when byte_valid=1.
- byte_valid  input  1  byte_in qualifier; no backpressure, bytes are never stalled.
- word_out  output  32  FIFO head word.
- word_fold  output  8  word_out[7:0]^[15:8]^[23:16]^[31:24]; combinational from head.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accept; pop when word_valid & word_ready.
- frame_err  output  1  one-cycle pulse on checksum mismatch.
- overflow  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.
- err_count  output  8  saturating count of frame_err plus overflow events.
- hunting  output  1  1 while in HUNT state.

Behaviour:
- Reset (rst_n=1 at an edge):
  - State becomes HUNT; FIFO is emptied.
  - word_valid, frame_err, overflow and err_count become 0; hunting becomes 1.
  - word_out and word_fold read 0 while the FIFO is empty.
  - Reset mid-frame discards the partial frame, with no error pulse.
- FSM, advancing only on cycles with byte_valid=1:
  - HUNT: byte==SYNC_BYTE -> PAYLOAD with idx=0 and chk=0; any other byte -> stay in HUNT.
  - PAYLOAD: store the byte into word lane idx (lane 0 = bits[7:0]); chk ^= byte; idx=3 -> CHECK, else idx+1.
  - CHECK: byte==chk -> push word and go to HUNT; mismatch -> pulse frame_err and go to HUNT.
  - A SYNC_BYTE value inside the payload or checksum position is ordinary data; there is no resync mid-frame.
  - Cycles with byte_valid=0 hold all state; there is no timeout.
- Latency: checksum byte sampled at edge N -> word_valid=1 from edge N (visible in cycle N+1) when the FIFO was empty.
- FIFO:
  - Count range 0..FIFO_DEPTH; write and read pointers wrap modulo FIFO_DEPTH.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle (full + pop + push keeps count=FIFO_DEPTH).
  - Simultaneous push and pop when empty: the pop is not valid (word_valid=0), so only the push takes effect and count becomes 1.
  - A rejected push pulses overflow; the word is lost and FSM returns to HUNT.
  - word_out, word_fold and word_valid must not change while word_valid=1 & word_ready=0.
- Error counter:
  - err_count increments by 1 per frame_err or overflow event and saturates at 255.
  - frame_err and overflow never occur in the same cycle.
- All outputs other than word_fold and word_out are registered.

Test Plan:
- Reset then stream A5,78,56,34,12,08 with word_ready=1 -> word_valid pulse with word_out=32'h12345678, word_fold=8'h08, err_count=0.
- Stream 00,FF,A5,01,02,03,04,04 -> hunting=1 through the first two bytes; word_out=32'h04030201 delivered; no errors.
- Stream A5,01,02,03,04,05 -> frame_err pulses exactly one cycle, err_count=1, word_valid stays 0, hunting=1 afterwards.
- With word_ready=0, send 5 good frames with payloads 1..5 -> after the 5th checksum overflow pulses and err_count=1; then raise word_ready -> words 1,2,3,4 emerge in order, each held stable while stalled.
- With the FIFO full and word_ready=1, a checksum byte arrives in the same cycle as a pop -> no overflow; count stays 4; the new word appears last.
- Assert rst_n after A5,11,22 -> post-reset stream A5,AA,BB,CC,DD,00 yields 32'hDDCCBBAA; 300 bad frames -> err_count holds at 255.

Source files
------------

// File: rtl/grid_word_deframer_if.sv
// Byte-stream input and word-FIFO output bundle for grid_word_deframer.
// The slave modport is the deframer side; the master modport is the producer/consumer side.
interface grid_word_deframer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [31:0] word_out;
  logic [7:0]  word_fold;
  logic        word_valid;
  logic        word_ready;
  logic        frame_err;
  logic        overflow;
  logic [7:0]  err_count;
  logic        hunting;

  modport slave (
    input  byte_in, byte_valid, word_ready,
    output word_out, word_fold, word_valid, frame_err, overflow, err_count, hunting
  );

  modport master (
    output byte_in, byte_valid, word_ready,
    input  word_out, word_fold, word_valid, frame_err, overflow, err_count, hunting
  );
endinterface

// File: rtl/grid_word_deframer.sv
// Rebuilds 32-bit grid words from a sync/payload/checksum byte stream and queues them in a small FIFO.
// The consumer side of the FIFO uses a valid/ready handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HUNT    | waiting for SYNC_BYTE; all other bytes are discarded
// ST_PAYLOAD | collecting 4 payload bytes LSB-first into r_word, XORing into r_chk
// ST_CHECK   | next byte is the checksum; a match pushes r_word, a mismatch pulses frame_err
module grid_word_deframer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  grid_word_deframer_if.slave   bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [7:0]    r_chk;
  logic [31:0]   r_word;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_word_valid;
  logic          r_frame_err;
  logic          r_overflow;
  logic          r_hunting;
  logic [7:0]    r_err_count;

  logic          w_check;
  logic          w_good;
  logic          w_bad;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_head;

  assign w_check = bus.byte_valid && (r_state == ST_CHECK);
  assign w_good  = w_check && (bus.byte_in == r_chk);
  assign w_bad   = w_check && (bus.byte_in != r_chk);
  assign w_pop   = r_word_valid && bus.word_ready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign w_push  = w_good && ((r_count != FULL_C) || w_pop);
  assign w_drop  = w_good && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state      <= ST_HUNT;
      r_idx        <= 2'd0;
      r_chk        <= 8'd0;
      r_word       <= 32'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
      r_hunting    <= 1'b1;
      r_err_count  <= 8'd0;
    end else begin
      r_frame_err <= w_bad;
      r_overflow  <= w_drop;
      if ((w_bad || w_drop) && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= r_word;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count      <= w_count_nxt;
      r_word_valid <= (w_count_nxt != '0);

      if (bus.byte_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (bus.byte_in == SYNC_BYTE) begin
              r_state   <= ST_PAYLOAD;
              r_idx     <= 2'd0;
              r_chk     <= 8'd0;
              r_hunting <= 1'b0;
            end
          end
          ST_PAYLOAD: begin
            r_word[{r_idx, 3'b000} +: 8] <= bus.byte_in;
            r_chk                        <= r_chk ^ bus.byte_in;
            if (r_idx == 2'd3) begin
              r_state <= ST_CHECK;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
          ST_CHECK: begin
            r_state   <= ST_HUNT;
            r_hunting <= 1'b1;
          end
          default: begin
            r_state   <= ST_HUNT;
            r_hunting <= 1'b1;
          end
        endcase
      end
    end
  end

  // Head reads as zero while empty so stale memory never leaks out.
  assign w_head = r_word_valid ? r_mem[r_rd_ptr] : 32'd0;

  assign bus.word_out   = w_head;
  assign bus.word_fold  = w_head[7:0] ^ w_head[15:8] ^ w_head[23:16] ^ w_head[31:24];
  assign bus.word_valid = r_word_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overflow   = r_overflow;
  assign bus.err_count  = r_err_count;
  assign bus.hunting    = r_hunting;

endmodule

// File: tb/tb_grid_word_deframer.sv
// Randomised and directed bench for grid_word_deframer: a frame-list reference model
// feeds a scoreboard queue that a negedge monitor drains on every handshake.
module tb_grid_word_deframer;
  localparam int DEPTH = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  grid_word_deframer_if bus();

  grid_word_deframer #(.SYNC_BYTE(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int delivered = 0;

  logic [7:0]  frm[$];
  logic [31:0] exp_q[$];
  int          m_count = 0;
  int          e_err = 0;
  bit          e_fe = 1'b0;
  bit          e_ov = 1'b0;
  bit          checking = 1'b0;

  logic        s_valid = 1'b0;
  logic        s_ready = 1'b0;
  logic        s_rst = 1'b1;
  logic [31:0] s_word = 32'd0;

  function automatic logic [7:0] fold(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is SYNC plus the next five accepted bytes, nothing more.
  always @(posedge clk) begin
    if (rst_n) begin
      frm.delete();
      exp_q.delete();
      m_count = 0;
      e_err = 0;
      e_fe = 1'b0;
      e_ov = 1'b0;
      checking = 1'b1;
    end else if (checking) begin
      bit          pop;
      bit          have;
      logic [31:0] w;
      pop  = (m_count > 0) && bus.word_ready;
      have = 1'b0;
      w    = 32'd0;
      e_fe = 1'b0;
      e_ov = 1'b0;
      if (bus.byte_valid) begin
        if (frm.size() == 0) begin
          if (bus.byte_in == SYNC) frm.push_back(bus.byte_in);
        end else begin
          frm.push_back(bus.byte_in);
          if (frm.size() == 6) begin
            w = {frm[4], frm[3], frm[2], frm[1]};
            if (frm[5] == (frm[1] ^ frm[2] ^ frm[3] ^ frm[4])) have = 1'b1;
            else e_fe = 1'b1;
            frm.delete();
          end
        end
      end
      if (pop) m_count--;
      if (have) begin
        if (m_count < DEPTH) begin
          exp_q.push_back(w);
          m_count++;
        end else begin
          e_ov = 1'b1;
        end
      end
      if ((e_fe || e_ov) && e_err < 255) e_err++;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("word_valid", {31'd0, bus.word_valid}, {31'd0, m_count > 0});
      chk("hunting", {31'd0, bus.hunting}, {31'd0, frm.size() == 0});
      chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e_fe});
      chk("overflow", {31'd0, bus.overflow}, {31'd0, e_ov});
      chk("err_count", {24'd0, bus.err_count}, 32'(e_err));
      if (m_count > 0) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'(exp_q.size()), 32'(m_count));
        end else begin
          chk("word_out", bus.word_out, exp_q[0]);
          chk("word_fold", {24'd0, bus.word_fold}, {24'd0, fold(exp_q[0])});
        end
      end else begin
        chk("word_out_empty", bus.word_out, 32'd0);
        chk("word_fold_empty", {24'd0, bus.word_fold}, 32'd0);
      end
      if (s_valid && !s_ready && !s_rst) begin
        chk("stall_valid", {31'd0, bus.word_valid}, 32'd1);
        chk("stall_word", bus.word_out, s_word);
      end
      if (m_count > 0 && bus.word_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      s_valid = bus.word_valid;
      s_ready = bus.word_ready;
      s_word  = bus.word_out;
      s_rst   = rst_n;
    end
  end

  task automatic put(input logic [7:0] b, input logic v, input logic r);
    bus.byte_in    = b;
    bus.byte_valid = v;
    bus.word_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [31:0] w, input logic r, input bit corrupt);
    put(SYNC, 1'b1, r);
    for (int i = 0; i < 4; i++) put(w[8*i +: 8], 1'b1, r);
    put(corrupt ? (fold(w) ^ 8'h5A) : fold(w), 1'b1, r);
  endtask

  task automatic reset_dut();
    rst_n = 1'b1;
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && m_count > 0; i++) put(8'h00, 1'b0, 1'b1);
    chk("drained", {31'd0, bus.word_valid}, 32'd0);
  endtask

  task automatic rput(input logic [7:0] b);
    while ($urandom_range(0, 3) == 0) put(8'h3C, 1'b0, $urandom_range(0, 3) != 0);
    put(b, 1'b1, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    int d0;
    logic [31:0] w;
    logic [7:0]  seq2 [8];
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.word_ready = 1'b0;
    reset_dut();
    chk("reset_hunting", {31'd0, bus.hunting}, 32'd1);
    chk("reset_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("reset_err", {24'd0, bus.err_count}, 32'd0);

    // Basic frame, checksum 08.
    d0 = delivered;
    put(8'hA5, 1'b1, 1'b1); put(8'h78, 1'b1, 1'b1); put(8'h56, 1'b1, 1'b1);
    put(8'h34, 1'b1, 1'b1); put(8'h12, 1'b1, 1'b1); put(8'h08, 1'b1, 1'b1);
    chk("t1_word", bus.word_out, 32'h12345678);
    chk("t1_fold", {24'd0, bus.word_fold}, 32'h08);
    put(8'h00, 1'b0, 1'b1);
    chk("t1_delivered", 32'(delivered - d0), 32'd1);

    // Leading noise before the sync byte.
    seq2 = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    d0 = delivered;
    for (int i = 0; i < 8; i++) begin
      put(seq2[i], 1'b1, 1'b1);
      if (i < 2) chk("t2_hunting", {31'd0, bus.hunting}, 32'd1);
    end
    chk("t2_word", bus.word_out, 32'h04030201);
    put(8'h00, 1'b0, 1'b1);
    chk("t2_delivered", 32'(delivered - d0), 32'd1);
    chk("t2_err", {24'd0, bus.err_count}, 32'd0);

    // Bad checksum.
    put(8'hA5, 1'b1, 1'b1); put(8'h01, 1'b1, 1'b1); put(8'h02, 1'b1, 1'b1);
    put(8'h03, 1'b1, 1'b1); put(8'h04, 1'b1, 1'b1); put(8'h05, 1'b1, 1'b1);
    chk("t3_frame_err", {31'd0, bus.frame_err}, 32'd1);
    put(8'h00, 1'b0, 1'b1);
    chk("t3_pulse_end", {31'd0, bus.frame_err}, 32'd0);
    chk("t3_err", {24'd0, bus.err_count}, 32'd1);
    chk("t3_valid", {31'd0, bus.word_valid}, 32'd0);

    // Fill with consumer stalled, fifth frame overflows.
    reset_dut();
    for (int k = 1; k <= 5; k++) frame(32'(k), 1'b0, 1'b0);
    chk("t4_overflow", {31'd0, bus.overflow}, 32'd1);
    chk("t4_err", {24'd0, bus.err_count}, 32'd1);
    for (int i = 0; i < 3; i++) put(8'h00, 1'b0, 1'b0);
    chk("t4_head", bus.word_out, 32'd1);
    d0 = delivered;
    drain();
    chk("t4_delivered", 32'(delivered - d0), 32'd4);

    // Full FIFO, checksum arrives together with a pop.
    for (int k = 0; k < 4; k++) frame(32'h1100_0000 + 32'(k), 1'b0, 1'b0);
    w = 32'hCAFE_0042;
    put(SYNC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) put(w[8*i +: 8], 1'b1, 1'b0);
    put(fold(w), 1'b1, 1'b1);
    chk("t5_no_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("t5_valid", {31'd0, bus.word_valid}, 32'd1);
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    drain();
    chk("t5_err", {24'd0, bus.err_count}, 32'd1);

    // Reset in the middle of a frame.
    put(8'hA5, 1'b1, 1'b1); put(8'h11, 1'b1, 1'b1); put(8'h22, 1'b1, 1'b1);
    reset_dut();
    put(8'hA5, 1'b1, 1'b1); put(8'hAA, 1'b1, 1'b1); put(8'hBB, 1'b1, 1'b1);
    put(8'hCC, 1'b1, 1'b1); put(8'hDD, 1'b1, 1'b1); put(8'h00, 1'b1, 1'b1);
    chk("t6_word", bus.word_out, 32'hDDCCBBAA);
    chk("t6_err", {24'd0, bus.err_count}, 32'd0);
    for (int k = 0; k < 300; k++) frame($urandom, 1'b1, 1'b1);
    put(8'h00, 1'b0, 1'b1);
    chk("t6_saturate", {24'd0, bus.err_count}, 32'd255);

    // Random mix of good, corrupt and noise traffic.
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      w = $urandom;
      if (kind <= 8) begin
        rput(SYNC);
        for (int i = 0; i < 4; i++) rput(w[8*i +: 8]);
        rput((kind == 8) ? (fold(w) ^ 8'(1 << $urandom_range(0, 7))) : fold(w));
      end else begin
        rput(8'($urandom));
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
